// File: rtl/apb_req_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module   : apb_req_bridge_pkg
// Brief    : Shared types and constants for the request-to-APB bridge.
// Revision : 1.0 - initial release
// ============================================================================
package apb_req_bridge_pkg;

  // Master FSM: one request becomes one SETUP phase plus one or more ACCESS cycles
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  // Read data returned when a transfer is aborted by the timeout
  localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

endpackage
`default_nettype wire

// File: rtl/apb_timeout_cnt.sv
`default_nettype none
// ============================================================================
// Module   : apb_timeout_cnt
// Brief    : Saturating ACCESS-phase cycle counter with an expiry flag.
//            expired_o is high once TIMEOUT_CYCLES-1 wait cycles have been
//            counted; TIMEOUT_CYCLES=0 disables expiry entirely.
// Revision : 1.0 - initial release
// ============================================================================
module apb_timeout_cnt #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYCLES + 1) < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] c_one = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise count up and stick at all-ones
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + c_one;
    end
  end

  // Counter register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_no_timeout
      assign expired_o = 1'b0;
    end else begin : g_timeout
      localparam logic [CNT_W-1:0] c_last = CNT_W'(TIMEOUT_CYCLES - 1);
      assign expired_o = (cnt_q == c_last);
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/apb_req_bridge.sv
`default_nettype none
// ============================================================================
// Module   : apb_req_bridge
// Brief    : Converts a req/gnt/rvalid peripheral port into single APB
//            transfers, with a registered response and an ACCESS timeout.
// Revision : 1.0 - initial release
// ============================================================================
module apb_req_bridge
  import apb_req_bridge_pkg::*;
#(
  parameter int unsigned APB_ADDR_WIDTH = 32,
  parameter int unsigned APB_DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      req_i,
  input  logic [APB_ADDR_WIDTH-1:0] addr_i,
  input  logic                      we_i,
  input  logic [APB_DATA_WIDTH-1:0] wdata_i,
  output logic                      gnt_o,
  output logic                      rvalid_o,
  output logic [APB_DATA_WIDTH-1:0] rdata_o,
  output logic                      err_o,
  output logic [APB_ADDR_WIDTH-1:0] paddr_o,
  output logic [APB_DATA_WIDTH-1:0] pwdata_o,
  output logic                      pwrite_o,
  output logic                      psel_o,
  output logic                      penable_o,
  input  logic [APB_DATA_WIDTH-1:0] prdata_i,
  input  logic                      pready_i,
  input  logic                      pslverr_i
);

  localparam logic [APB_DATA_WIDTH-1:0] c_timeout_rdata = APB_DATA_WIDTH'(TIMEOUT_RDATA);

  state_e                    state_q, state_d;
  logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [APB_DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic [APB_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                      pwrite_q, pwrite_d;
  logic                      rvalid_q, rvalid_d;
  logic                      err_q, err_d;
  logic                      w_cnt_clear;
  logic                      w_cnt_en;
  logic                      w_expired;

  // The counter restarts in SETUP and only counts ACCESS wait cycles
  assign w_cnt_clear = (state_q == SETUP);
  assign w_cnt_en    = (state_q == ACCESS) && !pready_i;

  apb_timeout_cnt #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clear_i   (w_cnt_clear),
    .en_i      (w_cnt_en),
    .expired_o (w_expired)
  );

  // Next state, captured request/response values and the combinational grant
  always_comb begin
    state_d  = state_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    pwrite_d = pwrite_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    rvalid_d = 1'b0;
    gnt_o    = 1'b0;
    case (state_q)
      IDLE: begin
        gnt_o = req_i;
        if (req_i) begin
          paddr_d  = addr_i;
          pwdata_d = wdata_i;
          pwrite_d = we_i;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        // A ready slave beats a simultaneous timeout
        if (pready_i) begin
          rvalid_d = 1'b1;
          rdata_d  = pwrite_q ? '0 : prdata_i;
          err_d    = pslverr_i;
          state_d  = IDLE;
        end else if (w_expired) begin
          rvalid_d = 1'b1;
          rdata_d  = c_timeout_rdata;
          err_d    = 1'b1;
          state_d  = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM state and all registered outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      paddr_q  <= '0;
      pwdata_q <= '0;
      pwrite_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      pwrite_q <= pwrite_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign psel_o    = (state_q != IDLE);
  assign penable_o = (state_q == ACCESS);
  assign paddr_o   = paddr_q;
  assign pwdata_o  = pwdata_q;
  assign pwrite_o  = pwrite_q;
  assign rvalid_o  = rvalid_q;
  assign rdata_o   = rdata_q;
  assign err_o     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_req_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_req_bridge
// Brief    : Directed self-checking bench for apb_req_bridge. Instance a uses
//            TIMEOUT_CYCLES=4, instance b has the timeout disabled.
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb_req_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        req_b = 1'b0;
  logic [31:0] addr = '0;
  logic        we = 1'b0;
  logic [31:0] wdata = '0;
  logic [31:0] prdata = '0;
  logic        pready = 1'b0;
  logic        pready_b = 1'b0;
  logic        pslverr = 1'b0;

  logic        gnt, rvalid, err, pwrite, psel, penable;
  logic [31:0] rdata, paddr, pwdata;
  logic        gnt_b, rvalid_b, err_b, pwrite_b, psel_b, penable_b;
  logic [31:0] rdata_b, paddr_b, pwdata_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  apb_req_bridge #(.APB_ADDR_WIDTH(32), .APB_DATA_WIDTH(32), .TIMEOUT_CYCLES(4)) dut_a (
    .clk_i(clk), .rst_i(rst), .req_i(req), .addr_i(addr), .we_i(we), .wdata_i(wdata),
    .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata), .err_o(err),
    .paddr_o(paddr), .pwdata_o(pwdata), .pwrite_o(pwrite), .psel_o(psel), .penable_o(penable),
    .prdata_i(prdata), .pready_i(pready), .pslverr_i(pslverr)
  );

  apb_req_bridge #(.APB_ADDR_WIDTH(32), .APB_DATA_WIDTH(32), .TIMEOUT_CYCLES(0)) dut_b (
    .clk_i(clk), .rst_i(rst), .req_i(req_b), .addr_i(addr), .we_i(we), .wdata_i(wdata),
    .gnt_o(gnt_b), .rvalid_o(rvalid_b), .rdata_o(rdata_b), .err_o(err_b),
    .paddr_o(paddr_b), .pwdata_o(pwdata_b), .pwrite_o(pwrite_b), .psel_o(psel_b), .penable_o(penable_b),
    .prdata_i(prdata), .pready_i(pready_b), .pslverr_i(pslverr)
  );

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step(); #1;
    checks++;
    if ({psel, penable, pwrite, rvalid, err, gnt} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl got %b exp 000000", {psel, penable, pwrite, rvalid, err, gnt});
    end
    checks++;
    if ({paddr, pwdata, rdata} !== 96'h0) begin
      errors++; $display("FAIL reset_data got %h exp 0", {paddr, pwdata, rdata});
    end
    checks++;
    if ({psel_b, penable_b, rvalid_b, err_b, paddr_b, rdata_b} !== 68'h0) begin
      errors++; $display("FAIL reset_b got %h exp 0", {psel_b, penable_b, rvalid_b, err_b, paddr_b, rdata_b});
    end
    step(); rst = 1'b0;
  endtask

  task automatic test_zero_wait_read();
    req = 1'b1; addr = 32'h1A10_0004; we = 1'b0; wdata = 32'h0; #1;       // T
    checks++;
    if ({gnt, psel} !== 2'b10) begin
      errors++; $display("FAIL zw_gnt got %b exp 10", {gnt, psel});
    end
    step(); req = 1'b0; #1;                                                // T+1
    checks++;
    if ({psel, penable, gnt, paddr, pwrite} !== {3'b100, 32'h1A10_0004, 1'b0}) begin
      errors++; $display("FAIL zw_setup got %h exp %h", {psel, penable, gnt, paddr, pwrite}, {3'b100, 32'h1A10_0004, 1'b0});
    end
    step(); pready = 1'b1; prdata = 32'h1234_5678; #1;                    // T+2
    checks++;
    if ({psel, penable, rvalid} !== 3'b110) begin
      errors++; $display("FAIL zw_access got %b exp 110", {psel, penable, rvalid});
    end
    step(); pready = 1'b0; prdata = 32'h0; #1;                            // T+3
    checks++;
    if ({rvalid, err, psel, penable, rdata} !== {4'b1000, 32'h1234_5678}) begin
      errors++; $display("FAIL zw_resp got %h exp %h", {rvalid, err, psel, penable, rdata}, {4'b1000, 32'h1234_5678});
    end
    step(); #1;                                                            // T+4
    checks++;
    if (rvalid !== 1'b0) begin
      errors++; $display("FAIL zw_pulse got %b exp 0", rvalid);
    end
  endtask

  // Three wait states put pready on the timeout expiry cycle: pready must win
  task automatic test_write_wait();
    req = 1'b1; addr = 32'h1A10_0008; we = 1'b1; wdata = 32'hCAFE_F00D; #1; // T
    checks++;
    if (gnt !== 1'b1) begin
      errors++; $display("FAIL ww_gnt got %b exp 1", gnt);
    end
    step(); req = 1'b0; addr = 32'h0; we = 1'b0; wdata = 32'h0; #1;       // T+1
    checks++;
    if ({psel, penable, pwrite, paddr, pwdata} !== {3'b101, 32'h1A10_0008, 32'hCAFE_F00D}) begin
      errors++; $display("FAIL ww_setup got %h exp %h", {psel, penable, pwrite, paddr, pwdata}, {3'b101, 32'h1A10_0008, 32'hCAFE_F00D});
    end
    for (int i = 0; i < 4; i++) begin                                      // T+2..T+5
      step();
      if (i == 3) begin pready = 1'b1; prdata = 32'hFFFF_FFFF; end
      #1;
      checks++;
      if ({psel, penable, pwrite, rvalid, paddr, pwdata} !== {4'b1110, 32'h1A10_0008, 32'hCAFE_F00D}) begin
        errors++; $display("FAIL ww_access%0d got %h exp %h", i, {psel, penable, pwrite, rvalid, paddr, pwdata}, {4'b1110, 32'h1A10_0008, 32'hCAFE_F00D});
      end
    end
    step(); pready = 1'b0; prdata = 32'h0; #1;                            // T+6
    checks++;
    if ({rvalid, err, psel, rdata} !== {3'b100, 32'h0}) begin
      errors++; $display("FAIL ww_resp got %h exp %h", {rvalid, err, psel, rdata}, {3'b100, 32'h0});
    end
    checks++;
    if ({paddr, pwdata} !== {32'h1A10_0008, 32'hCAFE_F00D}) begin
      errors++; $display("FAIL ww_hold got %h exp %h", {paddr, pwdata}, {32'h1A10_0008, 32'hCAFE_F00D});
    end
  endtask

  task automatic test_slave_err_back_to_back();
    step();
    req = 1'b1; addr = 32'h1A10_000C; we = 1'b0; #1;                       // T
    step(); req = 1'b0; #1;                                                // T+1
    step(); pready = 1'b1; pslverr = 1'b1; prdata = 32'h0BAD_0BAD; #1;    // T+2
    step(); pready = 1'b0; pslverr = 1'b0; prdata = 32'h0;                // T+3
    req = 1'b1; addr = 32'h1A10_0010; we = 1'b1; wdata = 32'h0000_00A5; #1;
    checks++;
    if ({rvalid, err, gnt, rdata} !== {3'b111, 32'h0BAD_0BAD}) begin
      errors++; $display("FAIL se_resp got %h exp %h", {rvalid, err, gnt, rdata}, {3'b111, 32'h0BAD_0BAD});
    end
    step(); req = 1'b0; #1;                                                // T+4
    checks++;
    if ({psel, penable, pwrite, rvalid, paddr, pwdata} !== {4'b1010, 32'h1A10_0010, 32'h0000_00A5}) begin
      errors++; $display("FAIL b2b_setup got %h exp %h", {psel, penable, pwrite, rvalid, paddr, pwdata}, {4'b1010, 32'h1A10_0010, 32'h0000_00A5});
    end
    step(); pready = 1'b1; #1;                                             // T+5
    step(); pready = 1'b0; #1;                                             // T+6
    checks++;
    if ({rvalid, err, rdata} !== {2'b10, 32'h0}) begin
      errors++; $display("FAIL b2b_resp got %h exp %h", {rvalid, err, rdata}, {2'b10, 32'h0});
    end
  endtask

  task automatic test_timeout();
    step();
    req = 1'b1; addr = 32'h1A10_0020; we = 1'b0; #1;                       // T
    step(); req = 1'b0; #1;                                                // T+1
    for (int i = 0; i < 4; i++) begin                                      // T+2..T+5
      step(); #1;
      checks++;
      if ({psel, penable, rvalid} !== 3'b110) begin
        errors++; $display("FAIL to_wait%0d got %b exp 110", i, {psel, penable, rvalid});
      end
    end
    step(); #1;                                                            // T+6
    checks++;
    if ({rvalid, err, psel, penable, rdata} !== {4'b1100, 32'hDEAD_BEEF}) begin
      errors++; $display("FAIL to_resp got %h exp %h", {rvalid, err, psel, penable, rdata}, {4'b1100, 32'hDEAD_BEEF});
    end
    step(); #1;                                                            // T+7
    checks++;
    if ({rvalid, psel} !== 2'b00) begin
      errors++; $display("FAIL to_after got %b exp 00", {rvalid, psel});
    end
  endtask

  task automatic test_tie_read();
    req = 1'b1; addr = 32'h1A10_0024; we = 1'b0; #1;                       // T
    step(); req = 1'b0; #1;                                                // T+1
    step(); #1; step(); #1; step(); #1;                                    // T+2..T+4
    step(); pready = 1'b1; prdata = 32'h55AA_33CC; #1;                    // T+5 expiry cycle
    step(); pready = 1'b0; prdata = 32'h0; #1;                            // T+6
    checks++;
    if ({rvalid, err, rdata} !== {2'b10, 32'h55AA_33CC}) begin
      errors++; $display("FAIL tie_resp got %h exp %h", {rvalid, err, rdata}, {2'b10, 32'h55AA_33CC});
    end
  endtask

  task automatic test_reset_mid();
    int bad;
    step();
    req = 1'b1; addr = 32'h1A10_0030; we = 1'b1; wdata = 32'h7777_8888; #1; // T
    step(); req = 1'b0; #1;                                                // T+1
    step(); #1;                                                            // T+2
    step(); rst = 1'b1; #1;                                                // T+3
    checks++;
    if ({psel, penable} !== 2'b11) begin
      errors++; $display("FAIL rm_before got %b exp 11", {psel, penable});
    end
    step(); rst = 1'b0; #1;                                                // T+4
    checks++;
    if ({psel, penable, pwrite, rvalid, err, paddr, pwdata, rdata} !== {5'b0, 96'h0}) begin
      errors++; $display("FAIL rm_reset got %h exp 0", {psel, penable, pwrite, rvalid, err, paddr, pwdata, rdata});
    end
    bad = 0;
    pready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(); #1;
      if (rvalid !== 1'b0 || psel !== 1'b0) bad++;
    end
    pready = 1'b0;
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL rm_no_rvalid got %0d bad cycles exp 0", bad);
    end
    req = 1'b1; addr = 32'h1A10_0034; we = 1'b1; wdata = 32'h1111_2222; #1;
    checks++;
    if (gnt !== 1'b1) begin
      errors++; $display("FAIL rm_regnt got %b exp 1", gnt);
    end
    step(); req = 1'b0; #1;
    step(); pready = 1'b1; #1;
    step(); pready = 1'b0; #1;
    checks++;
    if ({rvalid, err, rdata, paddr} !== {2'b10, 32'h0, 32'h1A10_0034}) begin
      errors++; $display("FAIL rm_resp got %h exp %h", {rvalid, err, rdata, paddr}, {2'b10, 32'h0, 32'h1A10_0034});
    end
  endtask

  task automatic test_no_timeout();
    int bad;
    step();
    req_b = 1'b1; addr = 32'h1A10_0040; we = 1'b0; #1;                     // T
    checks++;
    if (gnt_b !== 1'b1) begin
      errors++; $display("FAIL nt_gnt got %b exp 1", gnt_b);
    end
    step(); req_b = 1'b0; #1;                                              // T+1
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      step(); #1;
      if (rvalid_b !== 1'b0 || psel_b !== 1'b1 || penable_b !== 1'b1) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL nt_wait got %0d bad cycles exp 0", bad);
    end
    pready_b = 1'b1; prdata = 32'h600D_F00D;
    step(); pready_b = 1'b0; prdata = 32'h0; #1;
    checks++;
    if ({rvalid_b, err_b, psel_b, rdata_b} !== {3'b100, 32'h600D_F00D}) begin
      errors++; $display("FAIL nt_resp got %h exp %h", {rvalid_b, err_b, psel_b, rdata_b}, {3'b100, 32'h600D_F00D});
    end
    step(); #1;
    checks++;
    if (rvalid_b !== 1'b0) begin
      errors++; $display("FAIL nt_pulse got %b exp 0", rvalid_b);
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait_read();
    test_write_wait();
    test_slave_err_back_to_back();
    test_timeout();
    test_tie_read();
    test_reset_mid();
    test_no_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
